// File: rtl/pll_rst_seq.sv
// pll_rst_seq: reset sequencer for the system PLL.
// Runs on the free-running reference clock, which is the same net as the PLL refclk.
// Pulses the PLL reset, then waits for lock. Core reset is released only after
// the synchronised lock has been stable for STABLE_CYCLES cycles. A lock loss
// in RUN re-initialises the PLL.
//
// Optional feature: define PLL_RST_SEQ_TIMEOUT_EN to re-reset the PLL when it
// fails to lock within LOCK_TIMEOUT cycles.
//
// Ports:
//   clk          in  1  reference clock (PLL refclk)
//   rst          in  1  synchronous active-high reset
//   locked       in  1  PLL lock, asynchronous, synchronised internally
//   pll_rst      out 1  PLL reset, active-high
//   core_rst     out 1  core reset request, active-high, registered
//   ready        out 1  high exactly while in RUN
//   relock_count out 8  PLL reset re-issues since rst, saturating at 255
module pll_rst_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic [7:0] relock_count
);

  localparam int MAX_AB = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int MAX_P  = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
`ifdef PLL_RST_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nx;
  logic            sync1;
  logic            locked_s;
  logic            relock_inc;
  logic            pll_rst_nx;
  logic            core_rst_nx;
  logic            ready_nx;
  logic [7:0]      relock_nx;

  // State register. The synchroniser and the registered outputs share the register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RESET_PLL;
      cnt          <= '0;
      sync1        <= 1'b0;
      locked_s     <= 1'b0;
      pll_rst      <= 1'b1;
      core_rst     <= 1'b1;
      ready        <= 1'b0;
      relock_count <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      sync1        <= locked;
      locked_s     <= sync1;
      pll_rst      <= pll_rst_nx;
      core_rst     <= core_rst_nx;
      ready        <= ready_nx;
      relock_count <= relock_nx;
    end
  end

  // Next-state and shared counter
  always_comb begin
    state_nx   = state;
    relock_inc = 1'b0;
    case (state)
      RESET_PLL: begin
        if (cnt == RST_LAST) state_nx = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock is tested first, so it wins over a timeout on the same cycle
        if (locked_s) begin
          state_nx = STABLE;
        end
`ifdef PLL_RST_SEQ_TIMEOUT_EN
        else if (cnt == TO_LAST) begin
          state_nx   = RESET_PLL;
          relock_inc = 1'b1;
        end
`endif
      end
      STABLE: begin
        if (!locked_s) state_nx = WAIT_LOCK;
        else if (cnt == STABLE_LAST) state_nx = RUN;
      end
      RUN: begin
        if (!locked_s) begin
          state_nx   = RESET_PLL;
          relock_inc = 1'b1;
        end
      end
      default: state_nx = RESET_PLL;
    endcase

    cnt_nx = cnt;
    if (state_nx != state) begin
      cnt_nx = '0;
    end else begin
      case (state)
        RESET_PLL: cnt_nx = cnt + 1'b1;
        STABLE:    cnt_nx = cnt + 1'b1;
`ifdef PLL_RST_SEQ_TIMEOUT_EN
        WAIT_LOCK: cnt_nx = cnt + 1'b1;
`endif
        default:   cnt_nx = cnt;
      endcase
    end
  end

  // Output decode from the next state, so outputs change on the same edge as the state
  always_comb begin
    pll_rst_nx  = (state_nx == RESET_PLL);
    core_rst_nx = (state_nx != RUN);
    ready_nx    = (state_nx == RUN);
    relock_nx   = relock_count;
    if (relock_inc && (relock_count != 8'hFF)) relock_nx = relock_count + 8'd1;
  end

endmodule

// File: tb/tb_pll_rst_seq.sv
module tb_pll_rst_seq;

  localparam int R = 4;
  localparam int S = 8;
  localparam int T = 32;

  logic       clk;
  logic       rst;
  logic       locked;
  logic       pll_rst;
  logic       core_rst;
  logic       ready;
  logic [7:0] relock_count;

  int n_vec;
  int n_err;

  pll_rst_seq #(
    .RST_CYCLES   (R),
    .STABLE_CYCLES(S),
    .LOCK_TIMEOUT (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .locked      (locked),
    .pll_rst     (pll_rst),
    .core_rst    (core_rst),
    .ready       (ready),
    .relock_count(relock_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase plus a countdown of edges remaining in the phase.
  // Phase 0 = PLL reset pulse, 1 = waiting for lock, 2 = lock settling, 3 = running.
  int   m_phase;
  int   m_left;
  int   m_cnt;
  logic m_p1;
  logic m_p2;

  task automatic model_step(input logic r, input logic l);
    logic ls;
    ls = m_p2;
    if (r) begin
      m_phase = 0; m_left = R; m_cnt = 0; m_p1 = 1'b0; m_p2 = 1'b0;
    end else begin
      m_p2 = m_p1;
      m_p1 = l;
      case (m_phase)
        0: begin
          m_left--;
          if (m_left == 0) begin m_phase = 1; m_left = T; end
        end
        1: begin
          if (ls) begin
            m_phase = 2; m_left = S;
          end else begin
`ifdef PLL_RST_SEQ_TIMEOUT_EN
            m_left--;
            if (m_left == 0) begin
              m_phase = 0; m_left = R;
              if (m_cnt < 255) m_cnt++;
            end
`endif
          end
        end
        2: begin
          if (!ls) begin
            m_phase = 1; m_left = T;
          end else begin
            m_left--;
            if (m_left == 0) m_phase = 3;
          end
        end
        default: begin
          if (!ls) begin
            m_phase = 0; m_left = R;
            if (m_cnt < 255) m_cnt++;
          end
        end
      endcase
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance past the edge, compare all outputs to the model
  task automatic tick(input logic r, input logic l);
    logic [10:0] exp;
    rst = r;
    locked = l;
    @(posedge clk);
    #1;
    model_step(r, l);
    exp = {(m_phase == 0), (m_phase != 3), (m_phase == 3), 8'(m_cnt)};
    check("model", {21'd0, pll_rst, core_rst, ready, relock_count}, {21'd0, exp});
  endtask

  // Hold locked high until ready rises; n counts ticks including the one that raised ready
  task automatic wait_ready(input int bound, output int n, output logic saw_pll);
    n = 0;
    saw_pll = 1'b0;
    while (n < bound) begin
      tick(1'b0, 1'b1);
      n++;
      if (pll_rst) saw_pll = 1'b1;
      if (ready) break;
    end
    if (!ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within %0d cycles", bound);
    end
  endtask

  task automatic lose_lock();
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
  endtask

  typedef struct {
    logic       r;
    logic       l;
    logic       pll;
    logic       core;
    logic       rdy;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [24];

  initial begin
    int   n;
    logic saw;
    int   rises;
    logic prev;

    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    locked = 1'b0;
    m_phase = 0; m_left = R; m_cnt = 0; m_p1 = 1'b0; m_p2 = 1'b0;

    // Clean start: rst for 3 cycles, locked from cycle 10, release 10 edges later
    for (int i = 0; i < 24; i++) begin
      tbl[i].r    = (i < 3);
      tbl[i].l    = (i >= 10);
      tbl[i].pll  = (i < 6);
      tbl[i].rdy  = (i >= 20);
      tbl[i].core = !(i >= 20);
      tbl[i].cnt  = 8'd0;
    end
    for (int i = 0; i < 24; i++) begin
      tick(tbl[i].r, tbl[i].l);
      check($sformatf("clean_start[%0d]", i),
            {21'd0, pll_rst, core_rst, ready, relock_count},
            {21'd0, tbl[i].pll, tbl[i].core, tbl[i].rdy, tbl[i].cnt});
    end

    // Loss in RUN: two edges after locked drops, everything goes back into reset
    tick(1'b0, 1'b0);
    check("loss_e0_ready", 32'(ready), 32'd1);
    tick(1'b0, 1'b0);
    check("loss_e1_ready", 32'(ready), 32'd1);
    tick(1'b0, 1'b0);
    check("loss_e2_outputs", {21'd0, pll_rst, core_rst, ready, relock_count},
          {21'd0, 1'b1, 1'b1, 1'b0, 8'd1});
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0);
      check("loss_pll_pulse", 32'(pll_rst), 32'd1);
    end
    tick(1'b0, 1'b0);
    check("loss_pll_end", 32'(pll_rst), 32'd0);
    wait_ready(40, n, saw);
    check("loss_relock_latency", 32'(n), 32'd11);
    check("loss_relock_count", 32'(relock_count), 32'd1);

    // Glitch in STABLE: lock low for one cycle 5 cycles after STABLE entry
    tick(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    wait_ready(40, n, saw);
    check("glitch_release_latency", 32'(n), 32'd11);
    check("glitch_no_pll_pulse", 32'(saw), 32'd0);
    check("glitch_count", 32'(relock_count), 32'd0);

    // Build relock_count to 3, then reset in the middle of STABLE
    for (int k = 0; k < 3; k++) begin
      lose_lock();
      wait_ready(40, n, saw);
    end
    lose_lock();
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);
    check("mid_stable_count", 32'(relock_count), 32'd4);
    check("mid_stable_core", 32'(core_rst), 32'd1);
    tick(1'b1, 1'b1);
    check("mid_stable_rst", {21'd0, pll_rst, core_rst, ready, relock_count},
          {21'd0, 1'b1, 1'b1, 1'b0, 8'd0});
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
    wait_ready(40, n, saw);
    check("after_rst_release_latency", 32'(n), 32'd11);

    // No lock after reset: periodic pulses with the timeout, a single pulse without
    tick(1'b1, 1'b0);
    prev = pll_rst;
    rises = 0;
    for (int i = 0; i < 110; i++) begin
      tick(1'b0, 1'b0);
      if (pll_rst && !prev) begin
        rises++;
        check("nolock_count_at_pulse", 32'(relock_count), 32'(rises));
      end
      prev = pll_rst;
    end
`ifdef PLL_RST_SEQ_TIMEOUT_EN
    check("nolock_pulses", 32'(rises), 32'd3);
    check("nolock_final_count", 32'(relock_count), 32'd3);
`else
    check("nolock_pulses", 32'(rises), 32'd0);
    check("nolock_final_count", 32'(relock_count), 32'd0);
`endif

    // Saturation: 300 lock losses in RUN
    tick(1'b1, 1'b0);
    wait_ready(60, n, saw);
    for (int k = 0; k < 300; k++) begin
      lose_lock();
      wait_ready(40, n, saw);
    end
    check("saturation_count", 32'(relock_count), 32'd255);
    lose_lock();
    check("saturation_no_wrap", 32'(relock_count), 32'd255);

    // Randomised traffic against the model
    tick(1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic l;
      r = ($urandom_range(0, 399) == 0);
      l = locked;
      if ($urandom_range(0, 11) == 0) l = ~l;
      tick(r, l);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
